// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner arbitration with hold-limit preemption for a 16:1 mux select
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        gnt_valid
);
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state_q, state_d;
  logic [15:0] gnt_q, gnt_d, pool;
  logic [3:0] sel_q, sel_d, last_q, last_d, win, idx;
  logic [HW-1:0] hold_q, hold_d;
  logic gv_q, gv_d, found, keep, sat;
  always_comb begin
    // the owner is masked out, so one search serves idle, release and preempt alike
    pool = req & ~gnt_q;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      idx = last_q + 4'(i + 1);
      if (!found && pool[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    sat = (MAX_HOLD == 0) || (hold_q == HW'(MAX_HOLD));
    keep = (state_q == OWN) && req[sel_q] && !(MAX_HOLD != 0 && hold_q == HW'(MAX_HOLD) && |pool);
    state_d = state_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    last_d = last_q;
    hold_d = hold_q;
    gv_d = gv_q;
    if (keep) begin
      hold_d = sat ? hold_q : hold_q + HW'(1);
    end else if (found) begin
      state_d = OWN;
      gnt_d = 16'(1) << win;
      sel_d = win;
      last_d = win;
      hold_d = HW'(1);
      gv_d = 1'b1;
    end else begin
      state_d = IDLE;
      gnt_d = '0;
      gv_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      last_q <= 4'd15;
      hold_q <= '0;
      gv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      last_q <= last_d;
      hold_q <= hold_d;
      gv_q <= gv_d;
    end
  end
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign gnt_valid = gv_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed tests on a MAX_HOLD=4 and a MAX_HOLD=0 instance, checked against an ownership model
module tb_mux16_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] req_a = '0, req_b = '0;
  logic [15:0] gnt_a, gnt_b;
  logic [3:0] sel_a, sel_b;
  logic gv_a, gv_b;
  int total = 0, bad = 0;
  bit started = 1'b0;
  typedef struct {
    bit own;
    int owner;
    int last;
    int held;
  } model_t;
  model_t ma = '{0, 0, 15, 0};
  model_t mb = '{0, 0, 15, 0};
  always #5 clk = ~clk;
  mux16_rr_arbiter #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .sel(sel_a), .gnt_valid(gv_a));
  mux16_rr_arbiter #(.MAX_HOLD(0)) dut_b (.clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .sel(sel_b), .gnt_valid(gv_b));
  function automatic model_t step(model_t m, logic [15:0] r, int mh, logic rs);
    model_t n = m;
    int w = -1;
    if (rs) return '{0, 0, 15, 0};
    if (m.own && r[m.owner] && !(mh != 0 && m.held >= mh && (r & ~(16'(1) << m.owner)) != 0)) begin
      n.held = m.held + 1;
      return n;
    end
    for (int i = 0; i < 16; i++) begin
      int j = (m.last + 1 + i) % 16;
      if (w < 0 && r[j] && !(m.own && j == m.owner)) w = j;
    end
    if (w < 0) begin
      n.own = 0;
      return n;
    end
    return '{1, w, w, 1};
  endfunction
  always @(posedge clk) begin
    ma <= step(ma, req_a, 4, rst);
    mb <= step(mb, req_b, 0, rst);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      chk("model_gnt_a", 32'(gnt_a), ma.own ? 32'(1) << ma.owner : 32'd0);
      chk("model_sel_a", 32'(sel_a), 32'(ma.owner));
      chk("model_gv_a", 32'(gv_a), 32'(ma.own));
      chk("model_gnt_b", 32'(gnt_b), mb.own ? 32'(1) << mb.owner : 32'd0);
      chk("model_sel_b", 32'(sel_b), 32'(mb.owner));
      chk("model_gv_b", 32'(gv_b), 32'(mb.own));
      chk("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
      chk("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
      if (gv_a) chk("gnt_sel_a", 32'(gnt_a), 32'(16'(1) << sel_a));
      if (gv_b) chk("gnt_sel_b", 32'(gnt_b), 32'(16'(1) << sel_b));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_a(string name, logic [15:0] g, logic [3:0] s, logic v);
    chk({name, "_gnt"}, 32'(gnt_a), 32'(g));
    chk({name, "_sel"}, 32'(sel_a), 32'(s));
    chk({name, "_gv"}, 32'(gv_a), 32'(v));
  endtask
  task automatic exp_b(string name, logic [15:0] g, logic [3:0] s, logic v);
    chk({name, "_gnt"}, 32'(gnt_b), 32'(g));
    chk({name, "_sel"}, 32'(sel_b), 32'(s));
    chk({name, "_gv"}, 32'(gv_b), 32'(v));
  endtask
  initial begin
    logic [3:0] rot [4] = '{4'd5, 4'd10, 4'd15, 4'd0};
    tick();
    tick();
    exp_a("reset_a", 16'h0, 4'd0, 1'b0);
    exp_b("reset_b", 16'h0, 4'd0, 1'b0);
    rst = 1'b0;
    started = 1'b1;
    req_a = 16'h0001;
    tick();
    exp_a("first_grant", 16'h0001, 4'd0, 1'b1);
    req_a = 16'h0000;
    tick();
    exp_a("first_release", 16'h0000, 4'd0, 1'b0);
    req_b = 16'h8421;
    tick();
    exp_b("rot_start", 16'h0001, 4'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      req_b = 16'h8421 & ~(16'(1) << sel_b);
      tick();
      exp_b("rotation", 16'(1) << rot[k], rot[k], 1'b1);
    end
    req_b = 16'h0000;
    tick();
    exp_b("rot_idle", 16'h0000, 4'd0, 1'b0);
    req_b = 16'h4000;
    tick();
    exp_b("own14", 16'h4000, 4'd14, 1'b1);
    req_b = 16'h0003;
    tick();
    exp_b("wrap0", 16'h0001, 4'd0, 1'b1);
    req_b = 16'h4002;
    tick();
    exp_b("wrap1", 16'h0002, 4'd1, 1'b1);
    req_b = 16'h0000;
    tick();
    req_a = 16'h0008;
    tick();
    exp_a("pre_g", 16'h0008, 4'd3, 1'b1);
    req_a = 16'h0088;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_a("pre_hold3", 16'h0008, 4'd3, 1'b1);
    end
    tick();
    exp_a("pre_to7", 16'h0080, 4'd7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_a("pre_hold7", 16'h0080, 4'd7, 1'b1);
    end
    tick();
    exp_a("pre_back3", 16'h0008, 4'd3, 1'b1);
    req_a = 16'h0000;
    tick();
    exp_a("pre_idle", 16'h0000, 4'd3, 1'b0);
    req_a = 16'h0010;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_a("sole", 16'h0010, 4'd4, 1'b1);
    end
    req_a = 16'h0200;
    tick();
    exp_a("own9", 16'h0200, 4'd9, 1'b1);
    req_a = 16'h0201;
    rst = 1'b1;
    tick();
    exp_a("mid_reset", 16'h0000, 4'd0, 1'b0);
    rst = 1'b0;
    tick();
    exp_a("post_reset", 16'h0001, 4'd0, 1'b1);
    req_a = 16'h0000;
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
